// File: rtl/master_tx_sequencer_pkg.sv
// Shared definitions for the transaction sequencer and the receiving-side FSM:
// state encodings, opcode values and the fixed word-3 payloads.
package master_tx_sequencer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_ABORT = 3'd5;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  // MULT sends zero because the receiver computes the product itself.
  localparam logic [31:0] WORD3_MULT = 32'h0000_0000;
  localparam logic [31:0] WORD3_NOP  = 32'h0000_00FF;

  // Payload of the fourth word of a transaction.
  function automatic logic [31:0] word3_sel(input logic [1:0] op,
                                            input logic [31:0] addsub_result);
    case (op)
      OP_ADD, OP_SUB: return addsub_result;
      OP_MULT:        return WORD3_MULT;
      default:        return WORD3_NOP;
    endcase
  endfunction

endpackage

// File: rtl/master_tx_sequencer_tx_word_mux.sv
// Combinational selection of the 32-bit word for a given word index.
module tx_word_mux
  import master_tx_sequencer_pkg::*;
(
  input  logic [1:0]  word_idx,
  input  logic [1:0]  opcode,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [31:0] addsub_result,
  output logic [31:0] word
);

  // Word order: opcode, A, B, result/constant.
  always_comb begin
    word = '0;
    case (word_idx)
      2'd0:    word = {30'b0, opcode};
      2'd1:    word = operand_a;
      2'd2:    word = operand_b;
      default: word = word3_sel(opcode, addsub_result);
    endcase
  end

endmodule

// File: rtl/master_tx_sequencer.sv
// Sequences one 4-word I2C write transaction with inter-word gap,
// per-word NACK retry and per-word tx_done timeout.
module master_tx_sequencer
  import master_tx_sequencer_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRY      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [1:0]  opcode,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [31:0] addsub_result,
  output logic [31:0] tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  input  logic        tx_nack,
  output logic        busy,
  output logic        err,
  output logic [1:0]  word_idx,
  output logic [2:0]  state_out
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1) + 1;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [1:0]       word_idx_q, word_idx_d;
  logic             err_q, err_d;
  logic [31:0]      tx_data_q, tx_data_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]       sel_idx;
  logic [31:0]      mux_word;

  // In GAP the mux looks one word ahead so tx_data is ready on entry to SEND.
  assign sel_idx = (state_q == ST_GAP) ? word_idx_q + 2'd1 : word_idx_q;

  tx_word_mux u_mux (
    .word_idx      (sel_idx),
    .opcode        (op_q),
    .operand_a     (a_q),
    .operand_b     (b_q),
    .addsub_result (res_q),
    .word          (mux_word)
  );

  // Next-state and datapath control for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    word_idx_d = word_idx_q;
    err_d      = err_q;
    tx_data_d  = tx_data_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    case (state_q)
      ST_IDLE: if (go) begin
        op_d       = opcode;
        a_d        = operand_a;
        b_d        = operand_b;
        res_d      = addsub_result;
        err_d      = 1'b0;
        word_idx_d = 2'd0;
        retry_d    = '0;
        cnt_d      = '0;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        tx_data_d = mux_word;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          cnt_d = '0;
          if (!tx_nack) begin
            retry_d = '0;
            state_d = ST_GAP;
          end else if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = ST_GAP;
          end else begin
            state_d = ST_ABORT;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (retry_q != '0) begin
            // Re-send: tx_data still holds the NACKed word.
            state_d = ST_SEND;
          end else if (word_idx_q == 2'd3) begin
            word_idx_d = 2'd0;
            state_d    = ST_IDLE;
          end else begin
            word_idx_d = sel_idx;
            tx_data_d  = mux_word;
            state_d    = ST_SEND;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ABORT: begin
        err_d   = 1'b1;
        retry_d = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and latched transaction inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      retry_q    <= '0;
      word_idx_q <= 2'd0;
      err_q      <= 1'b0;
      tx_data_q  <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      word_idx_q <= word_idx_d;
      err_q      <= err_d;
      tx_data_q  <= tx_data_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = (state_q == ST_SEND);
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;
  assign word_idx  = word_idx_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_master_tx_sequencer.sv
// Randomized scoreboard bench for master_tx_sequencer with a scripted I2C slave.
module tb_master_tx_sequencer;

  localparam int G = 3;
  localparam int T = 20;
  localparam int R = 2;

  typedef struct {
    int kind;  // 0 ack, 1 nack, 2 never answers
    int dly;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [1:0]  opcode = '0;
  logic [31:0] operand_a = '0, operand_b = '0, addsub_result = '0;
  logic [31:0] tx_data;
  logic        tx_start, busy, err;
  logic [1:0]  word_idx;
  logic [2:0]  state_out;
  logic        slave_done = 1'b0, slave_nack = 1'b0;
  logic        spur_done = 1'b0, spur_nack = 1'b0;
  logic        tx_done, tx_nack;

  assign tx_done = slave_done | spur_done;
  assign tx_nack = slave_nack | spur_nack;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  resp_t       resp_q[$];
  int          exp_busy;
  logic        exp_err;

  master_tx_sequencer #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .MAX_RETRY(R)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .addsub_result(addsub_result),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .tx_nack(tx_nack),
    .busy(busy), .err(err), .word_idx(word_idx), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every tx_start pops the next expected word; word must hold until tx_done.
  initial begin
    logic [31:0] last = '0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_word unexpected send actual=%h expected=none", tx_data);
        end else begin
          check("tx_word", tx_data, exp_q.pop_front());
        end
        last = tx_data;
      end
      if (rst_n && tx_done && state_out == 3'd3) check("tx_hold", tx_data, last);
    end
  end

  // Slave: answers each tx_start according to the scripted response queue.
  initial begin
    resp_t rs;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start && resp_q.size() > 0) begin
        rs = resp_q.pop_front();
        if (rs.kind != 2) begin
          repeat (rs.dly + 1) @(negedge clk);
          slave_done = 1'b1;
          slave_nack = (rs.kind == 1);
          @(negedge clk);
          slave_done = 1'b0;
          slave_nack = 1'b0;
        end
      end
    end
  end

  // Builds the expected word stream, slave script, busy length and err outcome,
  // then issues go.  nk[i] = NACKs the slave gives word i; silent = word never answered.
  task automatic start_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input int nk0, input int nk1, input int nk2,
                           input int nk3, input int silent, input int fdly);
    int nk[4];
    logic [31:0] w[4];
    bit stop;
    int d;
    nk[0] = nk0; nk[1] = nk1; nk[2] = nk2; nk[3] = nk3;
    w[0] = {30'b0, op};
    w[1] = a;
    w[2] = b;
    w[3] = (op == 2'b00 || op == 2'b01) ? r : (op == 2'b10) ? 32'h0 : 32'hFF;
    exp_busy = 1;
    exp_err  = 1'b0;
    stop     = 1'b0;
    for (int i = 0; i < 4 && !stop; i++) begin
      for (int att = 0; att < 100; att++) begin
        d = (fdly < 0) ? int'($urandom_range(0, 3)) : fdly;
        exp_q.push_back(w[i]);
        if (i == silent) begin
          resp_q.push_back('{2, 0});
          exp_busy += 1 + T + 1;
          exp_err = 1'b1; stop = 1'b1;
          break;
        end
        if (att < nk[i]) begin
          resp_q.push_back('{1, d});
          if (att == R) begin
            exp_busy += 1 + (d + 1) + 1;
            exp_err = 1'b1; stop = 1'b1;
            break;
          end
          exp_busy += 2 + d + G;
        end else begin
          resp_q.push_back('{0, d});
          exp_busy += 2 + d + G;
          break;
        end
      end
    end
    @(negedge clk);
    opcode = op; operand_a = a; operand_b = b; addsub_result = r;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("busy_rise", {31'b0, busy}, 32'd1);
    check("err_clear_on_go", {31'b0, err}, 32'd0);
  endtask

  // Runs to IDLE while scrambling inputs and pulsing an ignored go.
  task automatic finish_txn();
    int n = 0;
    while (busy && n < 5000) begin
      n++;
      go = (n == 5);
      opcode = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
      addsub_result = $urandom;
      @(negedge clk);
    end
    go = 1'b0;
    check("busy_cycles", n, exp_busy);
    check("err_final", {31'b0, err}, {31'b0, exp_err});
    check("words_left", exp_q.size(), 0);
    check("resp_left", resp_q.size(), 0);
  endtask

  initial begin
    int n;
    int nkr[4];
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nkr[4];
    int sil, n;
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_start", {31'b0, tx_start}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_word_idx", {30'b0, word_idx}, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_state", {29'b0, state_out}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD, ideal master
    start_txn(2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 0, 0, -1, 0);
    finish_txn();
    // MULT
    start_txn(2'b10, 32'h40000000, 32'h40400000, 32'h12345678, 0, 0, 0, 0, -1, -1);
    finish_txn();
    // Two NACKs on word 1 then ACK
    start_txn(2'b01, $urandom, $urandom, $urandom, 0, 2, 0, 0, -1, -1);
    finish_txn();
    // Three NACKs on word 2: abort, err sticky
    start_txn(2'b11, $urandom, $urandom, $urandom, 0, 0, 3, 0, -1, -1);
    finish_txn();
    repeat (5) @(negedge clk);
    check("err_sticky", {31'b0, err}, 1);
    // Next go clears err (checked inside start_txn)
    start_txn(2'b00, $urandom, $urandom, $urandom, 0, 0, 0, 0, -1, -1);
    finish_txn();
    // Word 0 never answered: timeout abort
    start_txn(2'b01, $urandom, $urandom, $urandom, 0, 0, 0, 0, 0, -1);
    finish_txn();
    // tx_done in the last timeout cycle wins
    start_txn(2'b00, $urandom, $urandom, $urandom, 0, 0, 0, 0, -1, T - 1);
    finish_txn();

    // tx_done while idle is ignored
    @(negedge clk);
    spur_done = 1'b1; spur_nack = 1'b1;
    @(negedge clk);
    spur_done = 1'b0; spur_nack = 1'b0;
    @(negedge clk);
    check("idle_done_busy", {31'b0, busy}, 0);
    check("idle_done_state", {29'b0, state_out}, 0);

    // Reset during word 2 WAIT, with an ignored go along the way
    start_txn(2'b10, $urandom, $urandom, $urandom, 0, 0, 0, 0, 2, -1);
    n = 0;
    while (!(word_idx == 2'd2 && state_out == 3'd3) && n < 2000) begin
      n++;
      go = (n == 3);
      @(negedge clk);
    end
    go = 1'b0;
    check("reach_word2_wait", (n < 2000), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_start", {31'b0, tx_start}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_err", {31'b0, err}, 0);
    check("mid_rst_word_idx", {30'b0, word_idx}, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_state", {29'b0, state_out}, 0);
    check("mid_rst_words_left", exp_q.size(), 0);
    exp_q.delete();
    resp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start_txn(2'b01, $urandom, $urandom, $urandom, 0, 0, 0, 0, -1, -1);
    finish_txn();

    // Randomized transactions
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 4; i++) begin
        n = $urandom_range(0, 9);
        nkr[i] = (n < 6) ? 0 : (n < 8) ? 1 : (n == 8) ? 2 : 3;
      end
      sil = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      start_txn(2'($urandom), $urandom, $urandom, $urandom,
                nkr[0], nkr[1], nkr[2], nkr[3], sil, -1);
      finish_txn();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/master_tx_sequencer.md
MASTER_TX_SEQUENCER -- requirements
Module: master_tx_sequencer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16: idle clocks between consecutive words.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: max clocks waiting for tx_done per word.
REQ-003 SHALL have parameter MAX_RETRY, default 2: re-sends allowed per word after a NACK.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 go  in  1  one-cycle request to send one transaction; ignored unless idle.
REQ-007 opcode  in  2  00 ADD, 01 SUB, 10 MULT, 11 unused.
REQ-008 operand_a  in  32  IEEE-754 single operand A.
REQ-009 operand_b  in  32  IEEE-754 single operand B.
REQ-010 addsub_result  in  32  local adder/subtractor result.
REQ-011 tx_data  out  32  word presented to the I2C master; stable from tx_start until tx_done.
REQ-012 tx_start  out  1  one-cycle pulse requesting one 32-bit I2C write.
REQ-013 tx_done  in  1  one-cycle pulse: I2C write finished.
REQ-014 tx_nack  in  1  qualified by tx_done: slave did not acknowledge.
REQ-015 busy  out  1  high from go acceptance until return to IDLE.
REQ-016 err  out  1  sticky abort flag; cleared on next accepted go.
REQ-017 word_idx  out  2  index of current word (0..3), debug.
REQ-018 state_out  out  3  current state encoding, debug.

Function
REQ-019 States SHALL be IDLE, LOAD, SEND, WAIT, GAP, ABORT.
REQ-020 IDLE: on go, latch opcode/operand_a/operand_b/addsub_result, clear err, word_idx=0, retry=0 -> LOAD.
REQ-021 LOAD: select tx_data for word_idx -> SEND; inputs changing after acceptance SHALL NOT affect the transaction.
REQ-022 Word 0 SHALL be {30'b0, opcode}; word 1 operand_a; word 2 operand_b.
REQ-023 Word 3 SHALL be addsub_result for 00/01, 32'h0000_0000 for 10 (receiver multiplies), 32'h0000_00FF for 11.
REQ-024 SEND: assert tx_start for exactly one cycle, clear timeout counter -> WAIT.
REQ-025 WAIT: tx_done with tx_nack=0 -> GAP, retry=0; word_idx increments (3 wraps to 0) on leaving GAP.
REQ-026 WAIT: tx_done with tx_nack=1 and retry<MAX_RETRY -> retry+1, GAP then re-SEND same word_idx.
REQ-027 WAIT: tx_done with tx_nack=1 and retry==MAX_RETRY -> ABORT.
REQ-028 WAIT: counter reaching TIMEOUT_CYCLES-1 without tx_done -> ABORT; tx_done in that same cycle SHALL win.
REQ-029 GAP: count GAP_CYCLES clocks, then SEND next/retried word; after word 3 success -> IDLE.
REQ-030 ABORT: set err=1 for one cycle transition -> IDLE; err holds until next accepted go.
REQ-031 go while busy SHALL be ignored, no queueing.
REQ-032 tx_done outside WAIT SHALL be ignored.
REQ-033 Transaction latency with ideal master SHALL be 4 x (LOAD/SEND/WAIT overhead + master time + GAP_CYCLES) clocks; no words dropped or reordered.

Reset
REQ-034 rst_n low SHALL force IDLE, tx_start=0, busy=0, err=0, word_idx=0, tx_data=0, all counters and latches 0, at any time including mid-transaction.
REQ-035 After rst_n release, first go SHALL start a fresh word 0; no partial word resumed.

Structure
REQ-036 State encodings, opcode values (OP_ADD/SUB/MULT/NOP) and word-3 constants SHALL live in a shared package also used by the receiving-side FSM.
REQ-037 One sub-module natural: tx_word_mux (combinational word_idx/opcode -> tx_data selection); counters stay in the top.

Verification
REQ-038 ADD: opcode 00, A=3F800000, B=40000000, result=40400000, ideal master -> words 00000000,3F800000,40000000,40400000 in order, busy falls, err=0.
REQ-039 MULT: opcode 10, A=40000000, B=40400000 -> word 3 = 00000000, word 0 = 00000002.
REQ-040 NACK on word 1 twice then ACK -> word 1 sent 3 times, transaction completes, err=0.
REQ-041 NACK on word 2 three times -> ABORT, err=1, word 3 never sent, go accepted afterwards clears err.
REQ-042 Master never returns tx_done on word 0 -> ABORT after exactly TIMEOUT_CYCLES clocks in WAIT, err=1.
REQ-043 rst_n asserted during word 2 WAIT -> all outputs zero immediately; next go restarts at word 0; go pulsed while busy ignored.
